// File: rtl/out_port_capture_fifo.sv
// Captures the byte a CPU writes on one output port at the end of each write strobe and
// queues it for a valid/ready consumer. Define CAPTURE_TIMESTAMP_EN to tag entries with a cycle stamp.
module out_port_capture_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     port_strobe,
  input  logic [DATA_WIDTH-1:0]    port_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]      m_timestamp
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

  logic                  strobe_q;
  logic                  strobe_armed;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;

  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
  always_comb begin
    full    = 1'b0;
    m_valid = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    wr_en   = 1'b0;
    drop    = 1'b0;

    full    = (count == DEPTH_L);
    m_valid = (count != '0);
    // A strobe that was already high when reset released never counts as a write.
    push    = strobe_q && !port_strobe && strobe_armed;
    pop     = m_valid && m_ready;
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q     <= 1'b0;
      strobe_armed <= 1'b0;
      data_q       <= '0;
    end else begin
      strobe_q <= port_strobe;
      if (!port_strobe) strobe_armed <= 1'b1;
      if (port_strobe)  data_q       <= port_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is reset so the combinational head output reads 0 out of reset; DEPTH is small.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  assign m_data = mem[rd_ptr];
  assign level  = count;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
    end else if (wr_en) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign m_timestamp = ts_mem[rd_ptr];
`endif

endmodule
